mac_seq: RTL and testbench
==========================

Name: mac_seq

Overview:
- Initiator and consumer for the SNN neuron MAC.
- Walks N_IN operand pairs from synchronous input and weight memories, drives the MAC operand and clear interface, and waits for the final accumulation.
- Scales, rectifies and saturates the 26-bit accumulator to an 8-bit neuron output with a valid strobe.
- Sits between the layer controller (start/done) and one MAC instance.

Parameters:
- N_IN, 784: operand pairs per neuron evaluation (1..1023).
- ADDR_W, 10: memory address width; must satisfy N_IN <= 2^ADDR_W.
- SHIFT, 10: arithmetic right shift applied to acc before saturation (0..17).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous active-high reset
- start  in  1  begin one evaluation; sampled only in IDLE
- busy  out  1  high in RUN, DRAIN, OUT
- addr  out  ADDR_W  shared read address to input/weight memories
- mem_in  in  8  signed input value; valid 1 cycle after addr
- mem_wt  in  8  signed weight; valid 1 cycle after addr
- mac_in1  out  8  signed operand to MAC
- mac_in2  out  8  signed operand to MAC
- mac_clr_n  out  1  synchronous clear to MAC, active low
- acc  in  26  signed MAC accumulator (registered inside MAC)
- result  out  8  saturated neuron output
- result_vld  out  1  one-cycle strobe, result updated
- done  out  1  one-cycle strobe coincident with result_vld

Behaviour:
- Reset (async, rst=1): state=IDLE; addr=0; result=0; result_vld=0; done=0; busy=0; mac_clr_n=0; data-valid pipe bit v=0.
- IDLE: mac_clr_n=0, so the MAC holds 0; addr=0. When start=1 at an edge, go to RUN.
- RUN (exactly N_IN cycles):
  - Issue addr 0..N_IN-1, one per cycle.
  - v is addr-issued delayed by one cycle.
  - mac_clr_n=1.
  - After the cycle issuing N_IN-1, go to DRAIN.
- DRAIN (1 cycle): mac_clr_n=1; the last operand pair accumulates at the DRAIN->OUT edge.
- OUT (1 cycle):
  - acc holds the full sum.
  - At the OUT->IDLE edge, load result and set result_vld=1 and done=1 for exactly the first IDLE cycle.
- Operand gating: mac_in1 = v ? mem_in : 0; mac_in2 = v ? mem_wt : 0. Combinational from memory data; zero when not valid, so idle cycles add nothing.
- Latency: start sampled at edge k; addr 0 visible in cycle k+1; result_vld high in cycle k+N_IN+3.
- Arithmetic:
  - s = acc >>> SHIFT (sign-preserving).
  - Default mode is ReLU: s<0 -> 0; s>127 -> 127; else s[7:0].
- result holds its value until the next load; it is not cleared on start.
- start while busy: ignored, not queued.
- start in the cycle result_vld=1 (IDLE): accepted normally. MAC is already cleared because mac_clr_n=0 in OUT->IDLE, and clearing remains in force.
- mac_clr_n is also 0 during OUT, so acc is zeroed at the OUT->IDLE edge. result must be computed from acc during OUT.
- rst mid-operation: immediate abort to reset values; no done/result_vld; next start runs a full fresh evaluation.

Optional Feature:
- MAC_SEQ_SIGNED_OUT_EN defined: no rectification; signed saturation: s<-128 -> -128 (8'h80); s>127 -> 127; else s[7:0].
- Undefined: ReLU behaviour above.
- All other timing is identical in both modes.

Test Plan:
- N_IN=4, SHIFT=0, mem_in={1,2,3,4}, mem_wt={10,10,10,10}, start at edge k -> addr 0..3 in cycles k+1..k+4; result=100 (8'h64); result_vld and done high only in cycle k+7.
- Same, mem_wt={-10,-10,-10,-10} -> acc=-100; result=0; with MAC_SEQ_SIGNED_OUT_EN result=8'h9C.
- N_IN=4, mem_in=mem_wt=127: SHIFT=0 -> acc=64516, result=127 (both modes); SHIFT=10 -> result=63.
- N_IN=4, SHIFT=10, mem_in=mem_wt=-128 -> acc=65536, result=64; mem_in=-128 with mem_wt=127 -> acc=-65024, result=0 (ReLU) or -64 (8'hC0, signed mode).
- Two runs: pulse start again during RUN (ignored, busy stays 1); start in result_vld cycle with new data -> second result equals an isolated run of that data, proving acc was cleared.
- Assert rst during RUN at addr=2 -> all outputs at reset values within the same cycle, mac_clr_n=0, no done; release, start -> correct result per first scenario.

Source files
------------

// File: rtl/mac_seq_if.sv
// ---------------------------------------------------------------------------
// mac_seq_if : start/done, memory read and MAC operand bundle for mac_seq
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mac_seq_if #(
  parameter int ADDR_W = 10
) ();
  logic                     start;
  logic                     busy;
  logic        [ADDR_W-1:0] addr;
  logic signed [7:0]        mem_in;
  logic signed [7:0]        mem_wt;
  logic signed [7:0]        mac_in1;
  logic signed [7:0]        mac_in2;
  logic                     mac_clr_n;
  logic signed [25:0]       acc;
  logic        [7:0]        result;
  logic                     result_vld;
  logic                     done;

  // Sequencer side: drives addresses, MAC operands and the result.
  modport master (
    input  start, mem_in, mem_wt, acc,
    output busy, addr, mac_in1, mac_in2, mac_clr_n, result, result_vld, done
  );

  // Environment side: controller, memories and the MAC.
  modport slave (
    output start, mem_in, mem_wt, acc,
    input  busy, addr, mac_in1, mac_in2, mac_clr_n, result, result_vld, done
  );
endinterface

`default_nettype wire

// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq  : walks N_IN operand pairs into one MAC, then scales/saturates acc
//            to an 8-bit neuron output. MAC_SEQ_SIGNED_OUT_EN selects signed
//            saturation instead of ReLU.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_seq #(
  parameter int N_IN   = 784,
  parameter int ADDR_W = 10,
  parameter int SHIFT  = 10
) (
  input  logic     clk,
  input  logic     rst,
  mac_seq_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  addr;
  logic               v;
  logic               vld;
  logic [7:0]         result;
  logic [7:0]         sat;
  logic signed [25:0] s;
  logic               busy_c;
  logic               clr_n_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    clr_n_c   = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        clr_n_c = 1'b1;
        if (addr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        clr_n_c   = 1'b1;
        state_nxt = OUT;
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // v tracks that memory data on this cycle belongs to an issued address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      v      <= 1'b0;
      vld    <= 1'b0;
      result <= 8'h00;
    end else begin
      v   <= (state == RUN);
      vld <= (state == OUT);
      if (state == RUN && addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
      else                                   addr <= '0;
      if (state == OUT) result <= sat;
    end
  end

  assign s = bus.acc >>> SHIFT;

  always_comb begin
    sat = s[7:0];
`ifdef MAC_SEQ_SIGNED_OUT_EN
    if (s < -26'sd128)     sat = 8'h80;
    else if (s > 26'sd127) sat = 8'h7F;
`else
    if (s < 26'sd0)        sat = 8'h00;
    else if (s > 26'sd127) sat = 8'h7F;
`endif
  end

  assign bus.busy       = busy_c;
  assign bus.addr       = addr;
  assign bus.mac_clr_n  = clr_n_c;
  assign bus.mac_in1    = v ? bus.mem_in : 8'sd0;
  assign bus.mac_in2    = v ? bus.mem_wt : 8'sd0;
  assign bus.result     = result;
  assign bus.result_vld = vld;
  assign bus.done       = vld;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_seq : scoreboard bench for mac_seq, two instances (SHIFT=0, SHIFT=10)
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mac_seq;
  localparam int N_IN   = 4;
  localparam int ADDR_W = 4;
`ifdef MAC_SEQ_SIGNED_OUT_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  res;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cyc = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q[2][$];
  logic signed [7:0] min [16];
  logic signed [7:0] mwt [16];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  mac_seq_if #(.ADDR_W(ADDR_W)) b0 ();
  mac_seq_if #(.ADDR_W(ADDR_W)) b1 ();

  mac_seq #(.N_IN(N_IN), .ADDR_W(ADDR_W), .SHIFT(0))  dut0 (.clk(clk), .rst(rst), .bus(b0));
  mac_seq #(.N_IN(N_IN), .ADDR_W(ADDR_W), .SHIFT(10)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Synchronous-read memories and accumulating MACs
  always @(posedge clk) begin
    b0.mem_in <= min[b0.addr];
    b0.mem_wt <= mwt[b0.addr];
    b1.mem_in <= min[b1.addr];
    b1.mem_wt <= mwt[b1.addr];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b0.acc <= '0;
      b1.acc <= '0;
    end else begin
      if (!b0.mac_clr_n) b0.acc <= '0;
      else               b0.acc <= b0.acc + b0.mac_in1 * b0.mac_in2;
      if (!b1.mac_clr_n) b1.acc <= '0;
      else               b1.acc <= b1.acc + b1.mac_in1 * b1.mac_in2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int i, input logic vld, input logic dn, input logic [7:0] res);
    exp_t e;
    if (vld || dn) begin
      if (q[i].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out%0d: result_vld=%b done=%b expected none", i, vld, dn);
      end else begin
        e = q[i].pop_front();
        chk($sformatf("result%0d", i), {24'd0, res}, {24'd0, e.res});
        chk($sformatf("vld_cycle%0d", i), cyc, e.cyc);
        chk($sformatf("vld%0d", i), {31'd0, vld}, 32'd1);
        chk($sformatf("done%0d", i), {31'd0, dn}, 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.result_vld, b0.done, b0.result);
    mon(1, b1.result_vld, b1.done, b1.result);
  end

  task automatic load_mem(input logic [31:0] inv, input logic [31:0] wtv);
    for (int j = 0; j < 4; j++) begin
      min[j] = inv[8*j +: 8];
      mwt[j] = wtv[8*j +: 8];
    end
  endtask

  // Called at a negedge; returns at the negedge of the result_vld cycle.
  task automatic run(input logic [31:0] inv, input logic [31:0] wtv,
                     input logic [7:0] e0, input logic [7:0] e1, input bit poke);
    logic [31:0] t;
    load_mem(inv, wtv);
    b0.start = 1'b1;
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    t = cyc;
    q[0].push_back(exp_t'{res: e0, cyc: t + 32'd6});
    q[1].push_back(exp_t'{res: e1, cyc: t + 32'd6});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("addr", {28'd0, b0.addr}, j);
      chk("busy", {31'd0, b0.busy}, 32'd1);
      chk("clr_n", {31'd0, b0.mac_clr_n}, 32'd1);
      if (poke) begin
        b0.start = (j == 1);
        b1.start = (j == 1);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 16; j++) begin
      min[j] = 8'sd0;
      mwt[j] = 8'sd0;
    end
    b0.start = 1'b0;
    b1.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, b0.busy}, 32'd0);
    chk("rst_addr", {28'd0, b0.addr}, 32'd0);
    chk("rst_clr_n", {31'd0, b0.mac_clr_n}, 32'd0);
    chk("rst_result", {24'd0, b0.result}, 32'd0);
    chk("rst_vld", {31'd0, b0.result_vld}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_clr_n", {31'd0, b1.mac_clr_n}, 32'd0);

    run(32'h04030201, 32'h0A0A0A0A, 8'h64, 8'h00, 1'b0);
    run(32'h04030201, 32'hF6F6F6F6, SGN ? 8'h9C : 8'h00, SGN ? 8'hFF : 8'h00, 1'b0);
    run(32'h7F7F7F7F, 32'h7F7F7F7F, 8'h7F, 8'h3F, 1'b1);
    // back-to-back: starts in the result_vld cycle of the previous run
    run(32'h80808080, 32'h80808080, 8'h7F, 8'h40, 1'b0);
    run(32'h80808080, 32'h7F7F7F7F, SGN ? 8'h80 : 8'h00, SGN ? 8'hC0 : 8'h00, 1'b0);
    run(32'h04030201, 32'h0A0A0A0A, 8'h64, 8'h00, 1'b0);

    // abort mid-run with reset
    load_mem(32'h04030201, 32'h0A0A0A0A);
    b0.start = 1'b1;
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    for (int n = 0; n < 10 && b0.addr != 4'd2; n++) @(negedge clk);
    chk("abort_at_addr2", {28'd0, b0.addr}, 32'd2);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, b0.busy}, 32'd0);
    chk("abort_addr", {28'd0, b0.addr}, 32'd0);
    chk("abort_clr_n", {31'd0, b0.mac_clr_n}, 32'd0);
    chk("abort_result", {24'd0, b0.result}, 32'd0);
    chk("abort_vld", {31'd0, b0.result_vld}, 32'd0);
    chk("abort_done", {31'd0, b0.done}, 32'd0);
    chk("abort_mac_in1", {24'd0, b0.mac_in1}, 32'd0);
    chk("abort_busy1", {31'd0, b1.busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(32'h04030201, 32'h0A0A0A0A, 8'h64, 8'h00, 1'b0);

    repeat (5) @(negedge clk);
    chk("result_hold", {24'd0, b0.result}, 32'h64);
    chk("q0_drained", q[0].size(), 32'd0);
    chk("q1_drained", q[1].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
